// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-requester (icache/dcache) arbiter onto one memory port
//
// Purpose: grants either the icache line fill or the dcache fill/writeback
// to a single physical-memory port and routes the completion back.
// Optional: define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise the dcache always wins ties.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   i_read, i_addr                icache fill request and line address
//   i_resp, i_rdata               icache completion and fill data
//   d_read, d_write, d_addr       dcache fill / writeback request and address
//   d_wdata                       dcache writeback data
//   d_resp, d_rdata               dcache completion and fill data
//   pmem_read, pmem_write         registered memory commands
//   pmem_addr, pmem_wdata         registered memory address / write data
//   pmem_rdata, pmem_resp         memory read data and completion

module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_SERVE, D_SERVE} state_t;

  state_t state;
  state_t state_nxt;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // last_grant: 1 = dcache was granted last, 0 = icache.
  localparam logic LG_D = 1'b1;
  localparam logic LG_I = 1'b0;
  logic last_grant;

  // On a tie the side that did not win last time takes the grant.
  always_comb begin
    grant_d = d_req & (~i_read | (last_grant == LG_I));
    grant_i = i_read & ~grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= LG_D;
    end else if (state == IDLE) begin
      if (grant_d)      last_grant <= LG_D;
      else if (grant_i) last_grant <= LG_I;
    end
  end
`else
  always_comb begin
    grant_d = d_req;
    grant_i = i_read & ~d_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = D_SERVE;
        else if (grant_i) state_nxt = I_SERVE;
      end
      I_SERVE, D_SERVE: begin
        // Always pass through IDLE, so back-to-back grants get an idle gap.
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Command/address/data are captured once at grant and then frozen, so
  // requester changes during service cannot disturb the memory transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        // A simultaneous read and write from the dcache issues the writeback.
        pmem_read  <= d_read & ~d_write;
        pmem_write <= d_write;
        pmem_addr  <= d_addr;
        pmem_wdata <= d_wdata;
      end else if (grant_i) begin
        pmem_read  <= 1'b1;
        pmem_write <= 1'b0;
        pmem_addr  <= i_addr;
      end
    end else if (pmem_resp) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  assign i_resp  = (state == I_SERVE) & pmem_resp;
  assign d_resp  = (state == D_SERVE) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
